// File: rtl/inv_mod_2381_pkg.sv
// rtl/inv_mod_2381_pkg.sv - constants and state type for the GF(2381) inverse engine
package inv_mod_2381_pkg;

    localparam int             W   = 12;
    localparam int             PW  = 23;
    localparam logic [W-1:0]   Q   = 12'd2381;
    localparam logic [W-1:0]   EXP = 12'b1001_0100_1011;
    localparam logic [12:0]    MU  = 13'd7046;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/inv_mod_2381_if.sv
// rtl/inv_mod_2381_if.sv - operand/result handshake bundle for the inverse engine
interface inv_mod_2381_if;
    import inv_mod_2381_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] din_a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout_r;
    logic         dout_zero;

    modport master (
        output in_valid, din_a, out_ready,
        input  in_ready, out_valid, dout_r, dout_zero
    );

    modport slave (
        input  in_valid, din_a, out_ready,
        output in_ready, out_valid, dout_r, dout_zero
    );

endinterface

// File: rtl/inv_mod_2381_mod_mul.sv
// rtl/inv_mod_2381_mod_mul.sv - combinational a*b mod 2381 with Barrett reduction
module mod_mul_2381
    import inv_mod_2381_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] r_o
);

    logic [PW-1:0] prod;
    logic [10:0]   prod_hi;
    logic [23:0]   t_mu;
    logic [W-1:0]  t_est;
    logic [PW-1:0] t_q;
    logic [PW-1:0] rem0;
    logic [PW-1:0] rem1;
    logic [PW-1:0] rem2;

    // Quotient estimate undershoots floor(p/Q) by at most 2, so two
    // conditional subtracts always land the remainder in [0, Q).
    always_comb begin
        prod    = PW'(a_i) * PW'(b_i);
        prod_hi = 11'(prod >> 12);
        t_mu    = 24'(prod_hi) * 24'(MU);
        t_est   = 12'(t_mu >> 12);
        t_q     = PW'(t_est) * PW'(Q);
        rem0    = prod - t_q;
        rem1    = (rem0 >= PW'(Q)) ? rem0 - PW'(Q) : rem0;
        rem2    = (rem1 >= PW'(Q)) ? rem1 - PW'(Q) : rem1;
        r_o     = 12'(rem2);
    end

endmodule

// File: rtl/inv_mod_2381.sv
// rtl/inv_mod_2381.sv - Fermat modular inverse a^(Q-2) mod 2381, one multiply per cycle
module inv_mod_2381
    import inv_mod_2381_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    inv_mod_2381_if.slave  bus
);

    state_t       state_q, state_d;
    logic [W-1:0] base_q, base_d;
    logic [W-1:0] acc_q, acc_d;
    logic [3:0]   idx_q, idx_d;
    logic [W-1:0] dout_r_q, dout_r_d;
    logic         zero_q, zero_d;
    logic         ready_q;
    logic         valid_q;
    logic [W-1:0] din_fold;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_r;

    // Single shared multiplier: squares acc in SQR, multiplies by base in MUL.
    assign mul_b = (state_q == MUL) ? base_q : acc_q;

    mod_mul_2381 u_mul (
        .a_i (acc_q),
        .b_i (mul_b),
        .r_o (mul_r)
    );

    // 4095 < 2Q, so one conditional subtract fully reduces the raw operand.
    assign din_fold = (bus.din_a >= Q) ? bus.din_a - Q : bus.din_a;

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.dout_r    = dout_r_q;
    assign bus.dout_zero = zero_q;

    // Next-state: MSB-first square-and-multiply over the fixed exponent Q-2.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        dout_r_d = dout_r_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    base_d  = din_fold;
                    acc_d   = 12'd1;
                    idx_d   = 4'd11;
                    state_d = SQR;
                end
            end
            SQR: begin
                acc_d = mul_r;
                if (EXP[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            MUL: begin
                acc_d = mul_r;
                if (idx_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 4'd1;
                    state_d = SQR;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Result is latched once on entry to DONE and held through backpressure.
        if (state_d == DONE && state_q != DONE) begin
            dout_r_d = mul_r;
            zero_d   = (base_q == '0);
        end
    end

    // State and output registers; ready/valid are registered so neither is
    // visible while reset is held or in the handshake cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            dout_r_q <= '0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            dout_r_q <= dout_r_d;
            zero_q   <= zero_d;
            ready_q  <= (state_d == IDLE);
            valid_q  <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_inv_mod_2381.sv
// tb/tb_inv_mod_2381.sv - scoreboard bench for the GF(2381) inverse engine
module tb_inv_mod_2381;

    localparam int QM = 2381;

    typedef struct {
        int a;
        int r;
        bit z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    inv_mod_2381_if bus ();

    inv_mod_2381 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic int ref_inv(input int a_raw);
        int a, r, b, e;
        a = a_raw % QM;
        r = 1;
        b = a;
        e = QM - 2;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % QM;
            b = (b * b) % QM;
            e = e / 2;
        end
        return (a == 0) ? 0 : r;
    endfunction

    task automatic send_op(input int a, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            to = 1'b1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.din_a    = 12'(a);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.din_a    = 12'($urandom_range(4095));
    endtask

    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !bus.out_valid;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input int a, output int r, output bit z, output int lat, output bit to);
        r = 0;
        z = 1'b0;
        lat = 0;
        send_op(a, to);
        if (to) return;
        wait_out(lat, to);
        if (to) return;
        r = int'(bus.dout_r);
        z = bus.dout_zero;
        handshake();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.dout_r !== 12'd0) $display("FAIL reset_dout_r got %0d exp 0", bus.dout_r); else n_pass++;
        n_total++; if (bus.dout_zero !== 1'b0) $display("FAIL reset_dout_zero got %b exp 0", bus.dout_zero); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_first_op();
        int r, lat;
        bit z, to;
        exp_t e;
        sb.push_back('{a: 2, r: 1191, z: 1'b0});
        send_op(2, to);
        if (!to) wait_out(lat, to);
        n_total++; if (to) $display("FAIL first_timeout got timeout exp result"); else n_pass++;
        if (to) return;
        e = sb.pop_front();
        r = int'(bus.dout_r);
        z = bus.dout_zero;
        n_total++; if (lat !== 18) $display("FAIL first_latency got %0d exp 18", lat); else n_pass++;
        n_total++; if (r !== e.r) $display("FAIL first_dout_r got %0d exp %0d", r, e.r); else n_pass++;
        n_total++; if (z !== e.z) $display("FAIL first_dout_zero got %b exp %b", z, e.z); else n_pass++;
        handshake();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL first_valid_drop got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL first_ready_back got %b exp 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_values();
        int av[6] = '{1, 3, 2380, 0, 2381, 2383};
        int rv[6] = '{1, 794, 2380, 0, 0, 1191};
        bit zv[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int r, lat;
        bit z, to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{a: av[i], r: rv[i], z: zv[i]});
            run_op(av[i], r, z, lat, to);
            e = sb.pop_front();
            n_total++; if (to) $display("FAIL values_timeout a=%0d got timeout exp result", e.a); else n_pass++;
            n_total++; if (r !== e.r) $display("FAIL values_dout_r a=%0d got %0d exp %0d", e.a, r, e.r); else n_pass++;
            n_total++; if (z !== e.z) $display("FAIL values_dout_zero a=%0d got %b exp %b", e.a, z, e.z); else n_pass++;
            n_total++; if (lat !== 18) $display("FAIL values_latency a=%0d got %0d exp 18", e.a, lat); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int lat, r0;
        bit to;
        exp_t e;
        sb.push_back('{a: 9, r: ref_inv(9), z: 1'b0});
        send_op(9, to);
        if (!to) wait_out(lat, to);
        n_total++; if (to) $display("FAIL bp_timeout got timeout exp result"); else n_pass++;
        if (to) return;
        e = sb.pop_front();
        r0 = int'(bus.dout_r);
        n_total++; if (r0 !== e.r) $display("FAIL bp_dout_r got %0d exp %0d", r0, e.r); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.din_a    = 12'($urandom_range(1, 2380));
            @(posedge clk); #1;
            n_total++; if (int'(bus.dout_r) !== r0) $display("FAIL bp_stable cyc=%0d got %0d exp %0d", i, bus.dout_r, r0); else n_pass++;
            n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got %b exp 1", i, bus.out_valid); else n_pass++;
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready cyc=%0d got %b exp 0", i, bus.in_ready); else n_pass++;
        end
        bus.in_valid = 1'b0;
        handshake();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after got %b exp 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_valid_after got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int r, lat;
        bit z, to, seen;
        exp_t e;
        sb.push_back('{a: 7, r: ref_inv(7), z: 1'b0});
        send_op(7, to);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_ready got %b exp 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", bus.out_valid); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midrst_no_result got %b exp 0", seen); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_ready_after got %b exp 1", bus.in_ready); else n_pass++;
        sb.push_back('{a: 5, r: 1905, z: 1'b0});
        run_op(5, r, z, lat, to);
        e = sb.pop_front();
        n_total++; if (to) $display("FAIL midrst_next_timeout got timeout exp result"); else n_pass++;
        n_total++; if (r !== e.r) $display("FAIL midrst_next_dout_r got %0d exp %0d", r, e.r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int r, lat;
        bit z, to;
        exp_t e;
        int n_res;
        n_res = 0;
        for (int a = 1; a <= 2380; a++) begin
            sb.push_back('{a: a, r: ref_inv(a), z: 1'b0});
            run_op(a, r, z, lat, to);
            if (to) begin
                n_total++;
                $display("FAIL sweep_timeout a=%0d got timeout exp result", a);
                break;
            end
            n_res++;
            e = sb.pop_front();
            n_total++; if (r !== e.r) $display("FAIL sweep_dout_r a=%0d got %0d exp %0d", a, r, e.r); else n_pass++;
            n_total++; if ((r * a) % QM !== 1) $display("FAIL sweep_product a=%0d got %0d exp 1", a, (r * a) % QM); else n_pass++;
        end
        n_total++; if (n_res !== 2380) $display("FAIL sweep_count got %0d exp 2380", n_res); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL sweep_leftover got %0d exp 0", sb.size()); else n_pass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.din_a     = 12'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_first_op();
        test_values();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
